sel_mux_skid: RTL and testbench

//  Parametrised N-way, WIDTH-bit selector with a registered 2-entry skid buffer and valid/ready handshake.

---
 rtl/mux_pkg.sv | 16 +
 rtl/mux_n.sv | 26 ++
 rtl/sel_mux_skid.sv | 125 ++++++++++++
 tb/tb_sel_mux_skid.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared definitions for the selector/skid datapath: select-width helper and occupancy levels.
package mux_pkg;

  // Select width for an n-way selector; at least one bit even for degenerate n.
  function automatic int unsigned sel_w(input int unsigned n);
    return (n < 32'd2) ? 32'd1 : 32'($clog2(n));
  endfunction

  // Skid occupancy; the numeric value doubles as the exported level count.
  typedef enum logic [1:0] {
    LVL_EMPTY = 2'd0,
    LVL_ONE   = 2'd1,
    LVL_FULL  = 2'd2
  } level_e;

endpackage

// File: rtl/mux_n.sv
// Combinational N-way selector; out-of-range selects fall back to the last input and raise err.
module mux_n
  import mux_pkg::*;
#(
  parameter  int unsigned WIDTH = 32,
  parameter  int unsigned N_IN  = 4,
  localparam int unsigned SEL_W = sel_w(N_IN)
) (
  input  logic [SEL_W-1:0]      sel_i,
  input  logic [N_IN*WIDTH-1:0] data_i,
  output logic [WIDTH-1:0]      data_o_c,
  output logic                  err_o_c
);

  // Default to the last slice so that an out-of-range index needs no extra branch.
  always_comb begin
    data_o_c = data_i[(N_IN-1)*WIDTH +: WIDTH];
    err_o_c  = (32'(sel_i) >= N_IN);
    for (int unsigned k = 0; k < N_IN - 1; k++) begin
      if (32'(sel_i) == k) begin
        data_o_c = data_i[k*WIDTH +: WIDTH];
      end
    end
  end

endmodule

// File: rtl/sel_mux_skid.sv
// N-way selector feeding a registered 2-entry skid buffer with valid/ready on both sides.
module sel_mux_skid
  import mux_pkg::*;
#(
  parameter  int unsigned WIDTH = 32,
  parameter  int unsigned N_IN  = 4,
  localparam int unsigned SEL_W = sel_w(N_IN)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [SEL_W-1:0]      in_sel,
  input  logic [N_IN*WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic [SEL_W-1:0]      out_sel,
  output logic                  out_sel_err,
  output logic [1:0]            level
);

  level_e             level_q, level_d;
  logic [WIDTH-1:0]   main_data_q, main_data_d;
  logic [SEL_W-1:0]   main_sel_q,  main_sel_d;
  logic               main_err_q,  main_err_d;
  logic [WIDTH-1:0]   skid_data_q, skid_data_d;
  logic [SEL_W-1:0]   skid_sel_q,  skid_sel_d;
  logic               skid_err_q,  skid_err_d;

  logic [WIDTH-1:0]   word_data_c;
  logic               word_err_c;
  logic               accept_c;
  logic               pop_c;

  // Candidate word for this cycle; only stored when accepted.
  mux_n #(
    .WIDTH (WIDTH),
    .N_IN  (N_IN)
  ) u_mux (
    .sel_i    (in_sel),
    .data_i   (in_data),
    .data_o_c (word_data_c),
    .err_o_c  (word_err_c)
  );

  // Handshake flags decode from registered level only, so out_ready never reaches in_ready.
  assign in_ready  = (level_q != LVL_FULL) & ~rst;
  assign out_valid = (level_q != LVL_EMPTY);
  assign accept_c  = in_valid & in_ready;
  assign pop_c     = out_valid & out_ready;

  assign out_data    = main_data_q;
  assign out_sel     = main_sel_q;
  assign out_sel_err = main_err_q;
  assign level       = 2'(level_q);

  // Occupancy FSM: MAIN always holds the oldest word, SKID only the second one.
  always_comb begin
    level_d     = level_q;
    main_data_d = main_data_q;
    main_sel_d  = main_sel_q;
    main_err_d  = main_err_q;
    skid_data_d = skid_data_q;
    skid_sel_d  = skid_sel_q;
    skid_err_d  = skid_err_q;
    case (level_q)
      LVL_EMPTY: begin
        if (accept_c) begin
          main_data_d = word_data_c;
          main_sel_d  = in_sel;
          main_err_d  = word_err_c;
          level_d     = LVL_ONE;
        end
      end
      LVL_ONE: begin
        if (accept_c && pop_c) begin
          main_data_d = word_data_c;
          main_sel_d  = in_sel;
          main_err_d  = word_err_c;
        end else if (accept_c) begin
          skid_data_d = word_data_c;
          skid_sel_d  = in_sel;
          skid_err_d  = word_err_c;
          level_d     = LVL_FULL;
        end else if (pop_c) begin
          level_d = LVL_EMPTY;
        end
      end
      LVL_FULL: begin
        if (pop_c) begin
          main_data_d = skid_data_q;
          main_sel_d  = skid_sel_q;
          main_err_d  = skid_err_q;
          level_d     = LVL_ONE;
        end
      end
      default: begin
        level_d = LVL_EMPTY;
      end
    endcase
  end

  // State and storage registers; reset empties the buffer and clears both entries.
  always_ff @(posedge clk) begin
    if (rst) begin
      level_q     <= LVL_EMPTY;
      main_data_q <= '0;
      main_sel_q  <= '0;
      main_err_q  <= 1'b0;
      skid_data_q <= '0;
      skid_sel_q  <= '0;
      skid_err_q  <= 1'b0;
    end else begin
      level_q     <= level_d;
      main_data_q <= main_data_d;
      main_sel_q  <= main_sel_d;
      main_err_q  <= main_err_d;
      skid_data_q <= skid_data_d;
      skid_sel_q  <= skid_sel_d;
      skid_err_q  <= skid_err_d;
    end
  end

endmodule

// File: tb/tb_sel_mux_skid.sv
// Directed and randomized checks of sel_mux_skid across three parameterisations.
module tb_sel_mux_skid;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Instance A: WIDTH=32, N_IN=4
  logic         a_rst, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_err;
  logic [1:0]   a_in_sel, a_out_sel, a_level;
  logic [127:0] a_in_data;
  logic [31:0]  a_out_data;

  // Instance B: WIDTH=32, N_IN=3
  logic         b_rst, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_err;
  logic [1:0]   b_in_sel, b_out_sel, b_level;
  logic [95:0]  b_in_data;
  logic [31:0]  b_out_data;

  // Instance C: WIDTH=8, N_IN=5
  logic         c_rst, c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_out_err;
  logic [2:0]   c_in_sel, c_out_sel;
  logic [1:0]   c_level;
  logic [39:0]  c_in_data;
  logic [7:0]   c_out_data;

  sel_mux_skid #(.WIDTH(32), .N_IN(4)) u_a (
    .clk(clk), .rst(a_rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_sel(a_in_sel), .in_data(a_in_data), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .out_data(a_out_data), .out_sel(a_out_sel),
    .out_sel_err(a_out_err), .level(a_level)
  );

  sel_mux_skid #(.WIDTH(32), .N_IN(3)) u_b (
    .clk(clk), .rst(b_rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_sel(b_in_sel), .in_data(b_in_data), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .out_data(b_out_data), .out_sel(b_out_sel),
    .out_sel_err(b_out_err), .level(b_level)
  );

  sel_mux_skid #(.WIDTH(8), .N_IN(5)) u_c (
    .clk(clk), .rst(c_rst), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .in_sel(c_in_sel), .in_data(c_in_data), .out_valid(c_out_valid),
    .out_ready(c_out_ready), .out_data(c_out_data), .out_sel(c_out_sel),
    .out_sel_err(c_out_err), .level(c_level)
  );

  // Single comparison point for every check in the bench.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Slice k of instance A's bus becomes base + k, so the expected word is base + sel.
  task automatic a_fill(input logic [31:0] base);
    for (int k = 0; k < 4; k++) a_in_data[k*32 +: 32] = base + 32'(k);
  endtask

  // Reference model for instance C: an ideal FIFO of capacity two.
  typedef struct packed {
    logic [7:0] d;
    logic [2:0] s;
    logic       e;
  } rw_t;

  rw_t  q[$];
  rw_t  w;
  logic acc, pop;
  int   idx;

  initial begin
    a_rst = 1'b1; a_in_valid = 1'b0; a_in_sel = '0; a_in_data = '0; a_out_ready = 1'b0;
    b_rst = 1'b1; b_in_valid = 1'b0; b_in_sel = '0; b_in_data = '0; b_out_ready = 1'b0;
    c_rst = 1'b1; c_in_valid = 1'b0; c_in_sel = '0; c_in_data = '0; c_out_ready = 1'b0;

    // Reset held two cycles with valid input offered
    a_in_valid = 1'b1; a_in_sel = 2'd1; a_fill(32'h1111_0000); a_out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(a_out_valid), 32'd0);
    check("rst_in_ready",  32'(a_in_ready),  32'd0);
    check("rst_level",     32'(a_level),     32'd0);
    check("rst_out_data",  a_out_data,       32'h0);
    a_rst = 1'b0; a_in_valid = 1'b0;
    #1;
    check("rel_in_ready", 32'(a_in_ready), 32'd1);

    // Pass-through with one-cycle latency
    a_in_valid = 1'b1; a_in_sel = 2'd2; a_fill(32'hCAFE_0000);
    @(posedge clk); #1;
    check("pt_valid", 32'(a_out_valid), 32'd1);
    check("pt_data",  a_out_data,       32'hCAFE_0002);
    check("pt_sel",   32'(a_out_sel),   32'd2);
    check("pt_err",   32'(a_out_err),   32'd0);

    // Back-to-back words, one per cycle
    for (int i = 0; i < 4; i++) begin
      a_in_sel = 2'(i);
      a_fill(32'hB0B0_0000 + 32'(i << 8));
      @(posedge clk); #1;
      check("b2b_valid", 32'(a_out_valid), 32'd1);
      check("b2b_data",  a_out_data,       32'hB0B0_0000 + 32'(i << 8) + 32'(i));
      check("b2b_sel",   32'(a_out_sel),   32'(i));
    end
    a_in_valid = 1'b0;
    @(posedge clk); #1;
    check("b2b_drain_level", 32'(a_level), 32'd0);

    // Stall fills the skid; the head word holds until popped
    a_out_ready = 1'b0; a_in_valid = 1'b1;
    a_in_sel = 2'd0; a_fill(32'hAAAA_0000);
    @(posedge clk); #1;
    a_in_sel = 2'd1; a_fill(32'hBBBB_0000);
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    check("stall_level",    32'(a_level),    32'd2);
    check("stall_in_ready", 32'(a_in_ready), 32'd0);
    check("stall_data",     a_out_data,      32'hAAAA_0000);
    @(posedge clk); #1;
    check("stall_hold",     a_out_data,      32'hAAAA_0000);
    a_out_ready = 1'b1;
    @(posedge clk); #1;
    check("skid_data",  a_out_data,    32'hBBBB_0001);
    check("skid_sel",   32'(a_out_sel), 32'd1);
    check("skid_level", 32'(a_level),   32'd1);
    @(posedge clk); #1;
    check("skid_empty", 32'(a_level), 32'd0);

    // Reset while full: held words must vanish
    a_out_ready = 1'b0; a_in_valid = 1'b1;
    a_in_sel = 2'd0; a_fill(32'hAAAA_0000);
    @(posedge clk); #1;
    a_in_sel = 2'd1; a_fill(32'hBBBB_0000);
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    check("mid_full", 32'(a_level), 32'd2);
    a_rst = 1'b1;
    @(posedge clk); #1;
    check("mid_level", 32'(a_level),     32'd0);
    check("mid_valid", 32'(a_out_valid), 32'd0);
    check("mid_data",  a_out_data,       32'h0);
    a_rst = 1'b0; a_out_ready = 1'b1; a_in_valid = 1'b1;
    a_in_sel = 2'd3; a_fill(32'hCCCC_0000);
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    check("mid_c_data",  a_out_data,   32'hCCCC_0003);
    check("mid_c_level", 32'(a_level), 32'd1);
    @(posedge clk); #1;
    check("mid_after_level", 32'(a_level),     32'd0);
    check("mid_after_valid", 32'(a_out_valid), 32'd0);

    // Out-of-range select on a non-power-of-two instance
    b_rst = 1'b0; b_out_ready = 1'b1; b_in_valid = 1'b1;
    b_in_sel = 2'd3; b_in_data = {32'h0000_0055, 32'h0000_0011, 32'h0000_0022};
    @(posedge clk); #1;
    check("oor_data", b_out_data,       32'h0000_0055);
    check("oor_sel",  32'(b_out_sel),   32'd3);
    check("oor_err",  32'(b_out_err),   32'd1);
    b_in_sel = 2'd1;
    @(posedge clk); #1;
    b_in_valid = 1'b0;
    check("inr_data", b_out_data,     32'h0000_0011);
    check("inr_err",  32'(b_out_err), 32'd0);
    check("inr_lvl",  32'(b_level),   32'd1);

    // Random valid/ready/reset against the FIFO model
    for (int cyc = 0; cyc < 10000; cyc++) begin
      c_rst       = ($urandom_range(0, 199) == 0);
      c_in_valid  = 1'($urandom_range(0, 1));
      c_out_ready = ($urandom_range(0, 3) != 0) ^ (cyc[9] == 1'b1);
      c_in_sel    = 3'($urandom_range(0, 7));
      c_in_data   = 40'({$urandom, $urandom});
      #1;
      check("rnd_in_ready", 32'(c_in_ready), 32'(!c_rst && q.size() < 2));
      acc = c_in_valid && !c_rst && (q.size() < 2);
      pop = (q.size() > 0) && c_out_ready;
      idx = (int'(c_in_sel) < 5) ? int'(c_in_sel) : 4;
      w.d = c_in_data[idx*8 +: 8];
      w.s = c_in_sel;
      w.e = (int'(c_in_sel) >= 5);
      @(posedge clk);
      if (c_rst) begin
        q.delete();
      end else begin
        if (pop) void'(q.pop_front());
        if (acc) q.push_back(w);
      end
      #1;
      check("rnd_valid", 32'(c_out_valid), 32'(q.size() > 0));
      check("rnd_level", 32'(c_level),     32'(q.size()));
      if (q.size() > 0) begin
        check("rnd_data", 32'(c_out_data), 32'(q[0].d));
        check("rnd_sel",  32'(c_out_sel),  32'(q[0].s));
        check("rnd_err",  32'(c_out_err),  32'(q[0].e));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
